// File: rtl/pipeline_host_ctrl.sv
// Host-side sequencer for the 5-stage pipeline core.
// Owns the core's IMEM/DMEM host ports. Loads memories while the core is held in reset,
// runs the core for a programmed number of cycles, drains it, and reads DMEM back.
// Optional build macro: RUN_CYCLE_CNT_EN adds the run_cycles output, a saturating count of
// cycles the core spent out of reset during the most recent RUN.
module pipeline_host_ctrl #(
  parameter int unsigned IMEM_AW      = 9,
  parameter int unsigned DMEM_AW      = 8,
  parameter int unsigned DW           = 32,
  parameter int unsigned READ_LAT     = 1,
  parameter int unsigned DRAIN_CYCLES = 4,
  parameter int unsigned CNT_W        = 32
) (
  input  logic               clk,
  input  logic               rst,
  // Command interface
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [2:0]         cmd_op,
  input  logic [IMEM_AW-1:0] cmd_addr,
  input  logic [DW-1:0]      cmd_data,
  input  logic               halt_req,
  // Response / status
  output logic               rsp_valid,
  output logic [DW-1:0]      rsp_data,
  output logic               done,
  output logic               err,
  output logic               busy,
  // Core control and host memory ports
  output logic               pipe_rst,
  output logic               write_to_imem,
  output logic [IMEM_AW-1:0] addr_imem_host,
  output logic [DW-1:0]      data_imem_host,
  output logic               write_to_dmem,
  output logic [DMEM_AW-1:0] addr_dmem_host,
  output logic [DW-1:0]      data_dmem_host,
  output logic               read_req_dmem,
`ifdef RUN_CYCLE_CNT_EN
  output logic [CNT_W-1:0]   run_cycles,
`endif
  input  logic [DW-1:0]      data_out_dmem
);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_WRITE     = 3'd1;
  localparam logic [2:0] ST_READ_WAIT = 3'd2;
  localparam logic [2:0] ST_RUN       = 3'd3;
  localparam logic [2:0] ST_DRAIN     = 3'd4;

  localparam logic [2:0] OP_NOP     = 3'd0;
  localparam logic [2:0] OP_WR_IMEM = 3'd1;
  localparam logic [2:0] OP_WR_DMEM = 3'd2;
  localparam logic [2:0] OP_RD_DMEM = 3'd3;
  localparam logic [2:0] OP_RUN     = 3'd4;

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] READ_INIT = CNT_W'(READ_LAT);
  localparam logic [CNT_W-1:0] DRAIN_INIT = CNT_W'(DRAIN_CYCLES);

  // State and output registers
  logic [2:0]         r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_cmd_ready;
  logic               r_busy;
  logic               r_pipe_rst;
  logic               r_done;
  logic               r_err;
  logic               r_rsp_valid;
  logic [DW-1:0]      r_rsp_data;
  logic               r_wr_imem;
  logic [IMEM_AW-1:0] r_addr_imem;
  logic [DW-1:0]      r_data_imem;
  logic               r_wr_dmem;
  logic [DMEM_AW-1:0] r_addr_dmem;
  logic [DW-1:0]      r_data_dmem;
  logic               r_rd_req;

  // Next-state values
  logic [2:0]         w_state_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               w_pipe_rst_nxt;
  logic               w_done_nxt;
  logic               w_err_nxt;
  logic               w_rsp_valid_nxt;
  logic [DW-1:0]      w_rsp_data_nxt;
  logic               w_wr_imem_nxt;
  logic [IMEM_AW-1:0] w_addr_imem_nxt;
  logic [DW-1:0]      w_data_imem_nxt;
  logic               w_wr_dmem_nxt;
  logic [DMEM_AW-1:0] w_addr_dmem_nxt;
  logic [DW-1:0]      w_data_dmem_nxt;
  logic               w_rd_req_nxt;

  logic               w_accept;
  logic               w_run_start;

  // cmd_ready is only ever high in IDLE, so acceptance implies IDLE
  assign w_accept    = cmd_valid && r_cmd_ready;
  assign w_run_start = w_accept && (cmd_op == OP_RUN) && (cmd_data != '0);

  // Next-state and registered-output decode
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_pipe_rst_nxt  = r_pipe_rst;
    w_done_nxt      = 1'b0;
    w_err_nxt       = 1'b0;
    w_rsp_valid_nxt = 1'b0;
    w_rsp_data_nxt  = r_rsp_data;
    w_wr_imem_nxt   = 1'b0;
    w_addr_imem_nxt = r_addr_imem;
    w_data_imem_nxt = r_data_imem;
    w_wr_dmem_nxt   = 1'b0;
    w_addr_dmem_nxt = r_addr_dmem;
    w_data_dmem_nxt = r_data_dmem;
    w_rd_req_nxt    = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_pipe_rst_nxt = 1'b1;
        if (w_accept) begin
          case (cmd_op)
            OP_NOP: begin
            end
            OP_WR_IMEM: begin
              w_state_nxt     = ST_WRITE;
              w_wr_imem_nxt   = 1'b1;
              w_addr_imem_nxt = cmd_addr;
              w_data_imem_nxt = cmd_data;
            end
            OP_WR_DMEM: begin
              w_state_nxt     = ST_WRITE;
              w_wr_dmem_nxt   = 1'b1;
              w_addr_dmem_nxt = cmd_addr[DMEM_AW-1:0];
              w_data_dmem_nxt = cmd_data;
            end
            OP_RD_DMEM: begin
              w_state_nxt     = ST_READ_WAIT;
              w_rd_req_nxt    = 1'b1;
              w_addr_dmem_nxt = cmd_addr[DMEM_AW-1:0];
              w_cnt_nxt       = READ_INIT;
            end
            OP_RUN: begin
              if (cmd_data == '0) begin
                w_done_nxt = 1'b1;
              end else begin
                w_state_nxt    = ST_RUN;
                w_pipe_rst_nxt = 1'b0;
                w_cnt_nxt      = cmd_data[CNT_W-1:0];
              end
            end
            default: begin
              w_err_nxt = 1'b1;
            end
          endcase
        end
      end

      ST_WRITE: begin
        w_state_nxt = ST_IDLE;
      end

      ST_READ_WAIT: begin
        // A READ_LAT of 0 behaves like 1: data is sampled at the end of the request cycle
        if (r_cnt <= CNT_ONE) begin
          w_state_nxt     = ST_IDLE;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_data_nxt  = data_out_dmem;
        end else begin
          w_rd_req_nxt = 1'b1;
          w_cnt_nxt    = r_cnt - CNT_ONE;
        end
      end

      ST_RUN: begin
        if (halt_req || (r_cnt <= CNT_ONE)) begin
          if (DRAIN_CYCLES == 0) begin
            w_state_nxt    = ST_IDLE;
            w_pipe_rst_nxt = 1'b1;
            w_done_nxt     = 1'b1;
          end else begin
            w_state_nxt = ST_DRAIN;
            w_cnt_nxt   = DRAIN_INIT;
          end
        end else begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end
      end

      ST_DRAIN: begin
        if (r_cnt <= CNT_ONE) begin
          w_state_nxt    = ST_IDLE;
          w_pipe_rst_nxt = 1'b1;
          w_done_nxt     = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end
      end

      default: begin
        w_state_nxt    = ST_IDLE;
        w_pipe_rst_nxt = 1'b1;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_cmd_ready <= 1'b0;
      r_busy      <= 1'b0;
      r_pipe_rst  <= 1'b1;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_wr_imem   <= 1'b0;
      r_addr_imem <= '0;
      r_data_imem <= '0;
      r_wr_dmem   <= 1'b0;
      r_addr_dmem <= '0;
      r_data_dmem <= '0;
      r_rd_req    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_cmd_ready <= (w_state_nxt == ST_IDLE);
      r_busy      <= (w_state_nxt != ST_IDLE);
      r_pipe_rst  <= w_pipe_rst_nxt;
      r_done      <= w_done_nxt;
      r_err       <= w_err_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_data  <= w_rsp_data_nxt;
      r_wr_imem   <= w_wr_imem_nxt;
      r_addr_imem <= w_addr_imem_nxt;
      r_data_imem <= w_data_imem_nxt;
      r_wr_dmem   <= w_wr_dmem_nxt;
      r_addr_dmem <= w_addr_dmem_nxt;
      r_data_dmem <= w_data_dmem_nxt;
      r_rd_req    <= w_rd_req_nxt;
    end
  end

`ifdef RUN_CYCLE_CNT_EN
  logic [CNT_W-1:0] r_run_cycles;

  // Count cycles with the core out of reset; cleared at RUN start, saturating, held after done
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_run_cycles <= '0;
    end else if (w_run_start) begin
      r_run_cycles <= '0;
    end else if (!r_pipe_rst && (r_run_cycles != '1)) begin
      r_run_cycles <= r_run_cycles + CNT_ONE;
    end
  end

  assign run_cycles = r_run_cycles;
`else
  // Run-cycle counter not built; w_run_start has no other consumer
  logic w_unused_run_start;
  assign w_unused_run_start = w_run_start;
`endif

  assign cmd_ready      = r_cmd_ready;
  assign rsp_valid      = r_rsp_valid;
  assign rsp_data       = r_rsp_data;
  assign done           = r_done;
  assign err            = r_err;
  assign busy           = r_busy;
  assign pipe_rst       = r_pipe_rst;
  assign write_to_imem  = r_wr_imem;
  assign addr_imem_host = r_addr_imem;
  assign data_imem_host = r_data_imem;
  assign write_to_dmem  = r_wr_dmem;
  assign addr_dmem_host = r_addr_dmem;
  assign data_dmem_host = r_data_dmem;
  assign read_req_dmem  = r_rd_req;

endmodule

// File: tb/tb_pipeline_host_ctrl.sv
// Directed self-checking bench for pipeline_host_ctrl with a small DMEM model.
module tb_pipeline_host_ctrl;

  localparam int unsigned IMEM_AW = 9;
  localparam int unsigned DMEM_AW = 8;
  localparam int unsigned DW      = 32;
  localparam int unsigned CNT_W   = 32;

  logic               clk;
  logic               rst;
  logic               cmd_valid;
  logic               cmd_ready;
  logic [2:0]         cmd_op;
  logic [IMEM_AW-1:0] cmd_addr;
  logic [DW-1:0]      cmd_data;
  logic               halt_req;
  logic               rsp_valid;
  logic [DW-1:0]      rsp_data;
  logic               done;
  logic               err;
  logic               busy;
  logic               pipe_rst;
  logic               write_to_imem;
  logic [IMEM_AW-1:0] addr_imem_host;
  logic [DW-1:0]      data_imem_host;
  logic               write_to_dmem;
  logic [DMEM_AW-1:0] addr_dmem_host;
  logic [DW-1:0]      data_dmem_host;
  logic               read_req_dmem;
  logic [DW-1:0]      data_out_dmem;
`ifdef RUN_CYCLE_CNT_EN
  logic [CNT_W-1:0]   run_cycles;
`endif

  int n_cmp;
  int n_bad;

  pipeline_host_ctrl #(
    .IMEM_AW     (IMEM_AW),
    .DMEM_AW     (DMEM_AW),
    .DW          (DW),
    .READ_LAT    (1),
    .DRAIN_CYCLES(4),
    .CNT_W       (CNT_W)
  ) u_dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_op        (cmd_op),
    .cmd_addr      (cmd_addr),
    .cmd_data      (cmd_data),
    .halt_req      (halt_req),
    .rsp_valid     (rsp_valid),
    .rsp_data      (rsp_data),
    .done          (done),
    .err           (err),
    .busy          (busy),
    .pipe_rst      (pipe_rst),
    .write_to_imem (write_to_imem),
    .addr_imem_host(addr_imem_host),
    .data_imem_host(data_imem_host),
    .write_to_dmem (write_to_dmem),
    .addr_dmem_host(addr_dmem_host),
    .data_dmem_host(data_dmem_host),
    .read_req_dmem (read_req_dmem),
`ifdef RUN_CYCLE_CNT_EN
    .run_cycles    (run_cycles),
`endif
    .data_out_dmem (data_out_dmem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DMEM model: synchronous write, read data valid within the request cycle (READ_LAT = 1)
  logic [DW-1:0] dmem [256];
  always @(posedge clk) begin
    if (write_to_dmem) dmem[addr_dmem_host] <= data_dmem_host;
  end
  assign data_out_dmem = dmem[addr_dmem_host];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one command for a single edge; returns just after the accepting edge
  task automatic issue(input logic [2:0] op, input logic [IMEM_AW-1:0] addr,
                       input logic [DW-1:0] data);
    check("ready_before_cmd", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_data  = data;
    step();
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
    cmd_addr  = '0;
    cmd_data  = '0;
  endtask

  int low_cnt;
  int busy_cnt;
  int done_cnt;
  int done_at_release;
  int strobe_cnt;
  logic prev_low;

  // Observe a RUN from just after its accepting edge; halt asserted in run cycle halt_at
  task automatic watch_run(input int cycles, input int halt_at);
    low_cnt         = 0;
    busy_cnt        = 0;
    done_cnt        = 0;
    done_at_release = 0;
    strobe_cnt      = 0;
    prev_low        = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      if (!pipe_rst) low_cnt++;
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      if (done && pipe_rst && prev_low) done_at_release++;
      if (write_to_imem || write_to_dmem || read_req_dmem) strobe_cnt++;
      prev_low = !pipe_rst;
      halt_req = (c == halt_at);
      step();
    end
    halt_req = 1'b0;
  endtask

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    rst       = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
    cmd_addr  = '0;
    cmd_data  = '0;
    halt_req  = 1'b0;

    // Reset state
    step();
    step();
    check("rst_pipe_rst", 64'(pipe_rst), 64'd1);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    check("rst_outs", 64'({busy, done, err, rsp_valid, write_to_imem, write_to_dmem,
                           read_req_dmem}), 64'd0);
    rst = 1'b1;
    step();
    check("ready_after_rst", 64'(cmd_ready), 64'd1);

    // WR_IMEM: one-cycle strobe with captured address/data
    issue(3'd1, 9'h1A5, 32'hDEADBEEF);
    check("imem_we", 64'(write_to_imem), 64'd1);
    check("imem_addr", 64'(addr_imem_host), 64'h1A5);
    check("imem_data", 64'(data_imem_host), 64'hDEADBEEF);
    check("imem_pipe_rst", 64'(pipe_rst), 64'd1);
    check("imem_ready_low", 64'(cmd_ready), 64'd0);
    check("imem_busy", 64'(busy), 64'd1);
    step();
    check("imem_we_drop", 64'(write_to_imem), 64'd0);
    check("imem_ready_back", 64'(cmd_ready), 64'd1);

    // WR_DMEM two words, then read both back
    issue(3'd2, 9'h13C, 32'h12345678);
    check("dmem_we", 64'(write_to_dmem), 64'd1);
    check("dmem_addr", 64'(addr_dmem_host), 64'h3C);
    check("dmem_data", 64'(data_dmem_host), 64'h12345678);
    step();
    check("dmem_we_drop", 64'(write_to_dmem), 64'd0);
    issue(3'd2, 9'h03D, 32'hCAFEF00D);
    step();

    issue(3'd3, 9'h03C, 32'h0);
    check("rd_req", 64'(read_req_dmem), 64'd1);
    check("rd_addr", 64'(addr_dmem_host), 64'h3C);
    check("rd_no_rsp_yet", 64'(rsp_valid), 64'd0);
    step();
    check("rd_rsp_valid", 64'(rsp_valid), 64'd1);
    check("rd_rsp_data", 64'(rsp_data), 64'h12345678);
    check("rd_req_drop", 64'(read_req_dmem), 64'd0);
    check("rd_ready_back", 64'(cmd_ready), 64'd1);
    issue(3'd3, 9'h03D, 32'h0);
    check("rd2_rsp_pulse_end", 64'(rsp_valid), 64'd0);
    step();
    check("rd2_rsp_data", 64'(rsp_data), 64'hCAFEF00D);

    // RUN 10: 10 run + 4 drain cycles out of reset
    issue(3'd4, 9'h0, 32'd10);
    watch_run(30, -1);
    check("run10_low", 64'(low_cnt), 64'd14);
    check("run10_busy", 64'(busy_cnt), 64'd14);
    check("run10_done", 64'(done_cnt), 64'd1);
    check("run10_done_edge", 64'(done_at_release), 64'd1);
    check("run10_strobes", 64'(strobe_cnt), 64'd0);
`ifdef RUN_CYCLE_CNT_EN
    check("run10_cycles", 64'(run_cycles), 64'd14);
`endif

    // RUN 100 halted in run cycle 5: 6 run + 4 drain
    issue(3'd4, 9'h0, 32'd100);
    watch_run(40, 5);
    check("halt_low", 64'(low_cnt), 64'd10);
    check("halt_done", 64'(done_cnt), 64'd1);
    check("halt_done_edge", 64'(done_at_release), 64'd1);
`ifdef RUN_CYCLE_CNT_EN
    check("halt_cycles", 64'(run_cycles), 64'd10);
`endif

    // Illegal opcode, halt_req ignored in IDLE
    halt_req = 1'b1;
    issue(3'd6, 9'h0, 32'h0);
    check("ill_err", 64'(err), 64'd1);
    check("ill_idle", 64'({cmd_ready, busy, pipe_rst}), 64'b101);
    step();
    check("ill_err_drop", 64'(err), 64'd0);
    halt_req = 1'b0;

    // RUN 0: immediate done, core never released
    issue(3'd4, 9'h0, 32'd0);
    check("run0_done", 64'(done), 64'd1);
    check("run0_idle", 64'({cmd_ready, busy, pipe_rst}), 64'b101);
    step();
    check("run0_done_drop", 64'(done), 64'd0);
    check("run0_pipe_rst", 64'(pipe_rst), 64'd1);

    // Reset during the 3rd RUN cycle abandons the run
    issue(3'd4, 9'h0, 32'd20);
    step();
    step();
    check("mid_run_low", 64'(pipe_rst), 64'd0);
    rst = 1'b0;
    step();
    check("mid_rst_pipe_rst", 64'(pipe_rst), 64'd1);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_ready", 64'(cmd_ready), 64'd0);
`ifdef RUN_CYCLE_CNT_EN
    check("mid_rst_cycles", 64'(run_cycles), 64'd0);
`endif
    rst = 1'b1;
    step();
    check("mid_rst_ready_back", 64'(cmd_ready), 64'd1);
    watch_run(30, -1);
    check("mid_rst_no_done", 64'(done_cnt), 64'd0);
    check("mid_rst_no_low", 64'(low_cnt), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipeline_host_ctrl.md
Name: pipeline_host_ctrl

Overview:
- Host-side sequencer for the 5-stage pipeline core. It owns that core's host ports: write_to_imem/addr_imem_host/data_imem_host, write_to_dmem/addr_dmem_host/data_dmem_host, read_req_dmem and data_out_dmem.
- Accepts commands over a valid/ready interface. Loads IMEM/DMEM while the core is held in reset, runs the core for a programmed cycle count, drains in-flight instructions, then reads DMEM back.
- Sits between the host register interface and the pipeline top.

Parameters:
- IMEM_AW, 9, IMEM host address width.
- DMEM_AW, 8, DMEM host address width.
- DW, 32, data width.
- READ_LAT, 1, cycles from read_req_dmem assertion to valid data_out_dmem.
- DRAIN_CYCLES, 4, cycles the core keeps running after the count expires so in-flight instructions retire.
- CNT_W, 32, run-count width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller can accept a command.
- cmd_op  in  3  opcode: 0 NOP, 1 WR_IMEM, 2 WR_DMEM, 3 RD_DMEM, 4 RUN; 5-7 illegal.
- cmd_addr  in  9  IMEM address; DMEM uses [7:0].
- cmd_data  in  DW  write data, or run cycle count for RUN.
- halt_req  in  1  abort RUN early.
- rsp_valid  out  1  one-cycle pulse: rsp_data valid.
- rsp_data  out  DW  DMEM read data.
- done  out  1  one-cycle pulse when RUN completes.
- err  out  1  one-cycle pulse on illegal opcode.
- busy  out  1  high in any state except IDLE.
- pipe_rst  out  1  active-high hold of the core in reset.
- write_to_imem  out  1  IMEM write strobe.
- addr_imem_host  out  IMEM_AW  IMEM write address.
- data_imem_host  out  DW  IMEM write data.
- write_to_dmem  out  1  DMEM write strobe.
- addr_dmem_host  out  DMEM_AW  DMEM host address.
- data_dmem_host  out  DW  DMEM write data.
- read_req_dmem  out  1  DMEM host read request.
- data_out_dmem  in  DW  DMEM read data.

Behaviour:
- Reset (rst=0 at a clock edge):
  - Next state is IDLE.
  - pipe_rst=1; all other outputs 0.
  - Any in-progress write strobe, read or run is abandoned with no rsp_valid or done.
- Clock and handshake:
  - All outputs are registered.
  - A command is accepted when cmd_valid && cmd_ready. cmd_ready=1 only in IDLE and not in the cycle rst=0.
  - cmd fields are captured on acceptance and need not be held afterwards.
- FSM states: IDLE, WRITE, READ_WAIT, RUN, DRAIN.
- IDLE: pipe_rst=1, busy=0. On acceptance:
  - NOP: stay in IDLE, no effect.
  - Illegal opcode: err=1 for the next cycle, stay in IDLE.
  - WR_IMEM: go to WRITE; write_to_imem=1 for exactly the next cycle, with captured address and data.
  - WR_DMEM: go to WRITE; write_to_dmem=1 for exactly the next cycle, with addr_dmem_host=cmd_addr[7:0] and captured data.
  - RD_DMEM: go to READ_WAIT; read_req_dmem=1 with the address held for READ_LAT cycles.
    - At the end of the last cycle, sample data_out_dmem.
    - rsp_valid=1 with rsp_data for one cycle; return to IDLE that same cycle.
  - RUN with count 0: done pulses next cycle, stay in IDLE, pipe_rst stays 1.
  - RUN with count N>0: go to RUN; pipe_rst=0 from the next cycle.
- WRITE: lasts one cycle, then IDLE. The next command can be accepted 2 cycles after the previous acceptance.
- RUN:
  - Counter loads N and decrements each cycle; the core sees exactly N cycles with pipe_rst=0 before DRAIN.
  - At count 1, go to DRAIN.
  - halt_req=1 in RUN: go to DRAIN next cycle regardless of count.
  - halt_req is ignored in all other states.
- DRAIN:
  - pipe_rst stays 0 for DRAIN_CYCLES cycles.
  - Then pipe_rst=1 and done=1 in the same cycle, and state returns to IDLE.
- Host strobes (write_to_imem, write_to_dmem, read_req_dmem) are never asserted while pipe_rst=0. No host/core DMEM contention is possible.
- rsp_valid has no backpressure. The host must consume it in the pulse cycle.
- Counter arithmetic is unsigned CNT_W. An all-ones count is legal and does not wrap.

Optional Feature:
- Macro: RUN_CYCLE_CNT_EN.
- When defined:
  - Adds output run_cycles (CNT_W).
  - Cleared when a RUN with N>0 is accepted.
  - Increments every cycle pipe_rst=0, including DRAIN.
  - Holds its value after done; reset value 0; saturates at all-ones.
- When undefined: the port and logic do not exist, and all other behaviour is identical.

Test Plan:
- Reset, then WR_IMEM addr 0x1A5 data 0xDEADBEEF -> write_to_imem high exactly 1 cycle, addr_imem_host=0x1A5, data 0xDEADBEEF, pipe_rst=1 throughout, cmd_ready low that cycle.
- WR_DMEM addr 0x3C data 0x12345678, then RD_DMEM addr 0x3C (READ_LAT=1) -> rsp_valid pulses once with rsp_data=0x12345678, 2 cycles after RD acceptance.
- RUN N=10, DRAIN_CYCLES=4 -> pipe_rst low exactly 14 cycles, done pulses on the cycle pipe_rst returns to 1, busy high for 14 cycles, no host strobes; run_cycles=14 when the macro is defined.
- RUN N=100 with halt_req at run cycle 5 -> DRAIN entered next cycle, pipe_rst low 6+4=10 cycles total, done pulses once.
- cmd_op=6, and RUN N=0 -> err pulses 1 cycle and state unchanged; RUN 0 gives done next cycle with pipe_rst never low.
- rst=0 asserted in the 3rd RUN cycle -> next edge pipe_rst=1, busy=0, done never pulses, cmd_ready=1 the cycle after rst returns to 1.
